bsg_manycore_link_arbiter: RTL and testbench

Shares one manycore mesh edge input link (e.g. one `ver_data_i[N][c]` or `hor_data_i[W][r]` slot) among several off-array requesters such as host, DMA and loader.
- Picks one single-flit packet per cycle with round-robin priority.
- Registers it onto the link with valid/ready handshake.
- Keeps a per-requester outstanding-request counter, so no requester exceeds its share of in-flight remote operations.
- Counters are decremented by completion credits that the edge logic returns from the mesh.

---
 rtl/bsg_manycore_pkg.sv | 28 ++
 rtl/bsg_manycore_rr_pick.sv | 35 +++
 rtl/bsg_manycore_link_arbiter.sv | 124 ++++++++++++
 tb/tb_bsg_manycore_link_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore edge helpers: width functions and the requester id encoding.
// Used by the link arbiter and by the edge credit-return logic.
package bsg_manycore_pkg;

    // ceil(log2(n)), but never less than 1 so a 1-entry space still has a bit.
    function automatic int unsigned safe_clog2(input int unsigned n);
        int unsigned w;
        for (w = 1; (32'd1 << w) < n; w++) begin
        end
        return w;
    endfunction

    // Width of a requester id for num_req requesters.
    function automatic int unsigned req_id_width(input int unsigned num_req);
        return safe_clog2(num_req);
    endfunction

    // Width of an outstanding counter that must hold 0..max_out inclusive.
    function automatic int unsigned out_cnt_width(input int unsigned max_out);
        return safe_clog2(max_out + 1);
    endfunction

    localparam int unsigned default_num_req_lp = 4;

    // Requester id as carried on the credit-return path.
    typedef logic [req_id_width(default_num_req_lp)-1:0] req_id_t;

endpackage

// File: rtl/bsg_manycore_rr_pick.sv
// Combinational round-robin picker.
// Ports: eligible_i (per-requester eligibility), last_i (previous winner),
//        grant_o (one-hot winner), id_o (encoded winner), v_o (any winner).
module bsg_manycore_rr_pick
    import bsg_manycore_pkg::*;
#(
    parameter int unsigned num_req_p  = 4,
    parameter int unsigned id_width_p = req_id_width(num_req_p)
) (
    input  logic [num_req_p-1:0]  eligible_i,
    input  logic [id_width_p-1:0] last_i,
    output logic [num_req_p-1:0]  grant_o,
    output logic [id_width_p-1:0] id_o,
    output logic                  v_o
);

    logic [id_width_p-1:0] idx;

    // Search starts one past the last winner and wraps; first eligible wins.
    always_comb begin
        grant_o = '0;
        id_o    = '0;
        v_o     = 1'b0;
        idx     = '0;
        for (int unsigned off = 1; off <= num_req_p; off++) begin
            idx = id_width_p'((32'(last_i) + off) % num_req_p);
            if (!v_o && eligible_i[idx]) begin
                v_o          = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = idx;
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_link_arbiter.sv
// Shares one mesh edge input link among several requesters. Round-robin picks
// one single-flit packet per cycle into a registered valid/ready link slot and
// limits each requester to max_out_p in-flight packets via credit counters.
// Ports: clk_i/reset_i (async active-high), req_v_i/req_data_i/req_ready_o
//        (requester side), link_v_o/link_data_o/link_ready_i (link side),
//        credit_v_i/credit_id_i (completion return), out_cnt_o (counters),
//        err_o (sticky credit error).
module bsg_manycore_link_arbiter
    import bsg_manycore_pkg::*;
#(
    parameter int unsigned num_req_p      = 4,
    parameter int unsigned packet_width_p = 32,
    parameter int unsigned max_out_p      = 4,
    parameter int unsigned id_width_lp    = req_id_width(num_req_p),
    parameter int unsigned cnt_width_lp   = out_cnt_width(max_out_p)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_req_p-1:0]                     req_v_i,
    input  logic [num_req_p-1:0][packet_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                     req_ready_o,
    output logic                                     link_v_o,
    output logic [packet_width_p-1:0]                link_data_o,
    input  logic                                     link_ready_i,
    input  logic                                     credit_v_i,
    input  logic [id_width_lp-1:0]                   credit_id_i,
    output logic [num_req_p-1:0][cnt_width_lp-1:0]   out_cnt_o,
    output logic                                     err_o
);

    logic                                   link_v_q, link_v_d;
    logic [packet_width_p-1:0]              link_data_q, link_data_d;
    logic [num_req_p-1:0][cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [id_width_lp-1:0]                 last_q, last_d;
    logic                                   err_q, err_d;

    logic                   slot_free;
    logic [num_req_p-1:0]   eligible;
    logic [num_req_p-1:0]   pick_grant;
    logic [id_width_lp-1:0] pick_id;
    logic                   pick_v;
    logic                   credit_in_range;
    logic                   credit_ok;

    // Eligibility and slot availability; independent of packet data and credits.
    always_comb begin
        slot_free = !link_v_q || link_ready_i;
        eligible  = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            eligible[i] = req_v_i[i] && (cnt_q[i] < cnt_width_lp'(max_out_p));
        end
    end

    bsg_manycore_rr_pick #(
        .num_req_p  (num_req_p),
        .id_width_p (id_width_lp)
    ) u_rr_pick (
        .eligible_i (eligible),
        .last_i     (last_q),
        .grant_o    (pick_grant),
        .id_o       (pick_id),
        .v_o        (pick_v)
    );

    // Held during reset so nothing is handed off while the slot is being cleared.
    assign req_ready_o = (slot_free && !reset_i) ? pick_grant : '0;

    // A credit is only legal for an existing requester with something in flight.
    assign credit_in_range = (32'(credit_id_i) < num_req_p);
    assign credit_ok       = credit_v_i && credit_in_range && (cnt_q[credit_id_i] != '0);

    // Next state for output slot, counters, round-robin pointer and error flag.
    always_comb begin
        link_v_d    = link_v_q;
        link_data_d = link_data_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        err_d       = err_q;

        if (slot_free) begin
            link_v_d = pick_v;
            if (pick_v) begin
                link_data_d = req_data_i[pick_id];
                last_d      = pick_id;
            end
        end

        if (credit_v_i && !credit_ok) begin
            err_d = 1'b1;
        end

        // Grant and credit to the same requester cancel out.
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (req_ready_o[i] && !(credit_ok && (credit_id_i == id_width_lp'(i)))) begin
                cnt_d[i] = cnt_q[i] + cnt_width_lp'(1);
            end else if (!req_ready_o[i] && credit_ok && (credit_id_i == id_width_lp'(i))) begin
                cnt_d[i] = cnt_q[i] - cnt_width_lp'(1);
            end
        end
    end

    // Reset leaves requester 0 first in line.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            link_v_q    <= 1'b0;
            link_data_q <= '0;
            cnt_q       <= '0;
            last_q      <= id_width_lp'(num_req_p - 1);
            err_q       <= 1'b0;
        end else begin
            link_v_q    <= link_v_d;
            link_data_q <= link_data_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign link_v_o    = link_v_q;
    assign link_data_o = link_data_q;
    assign out_cnt_o   = cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_bsg_manycore_link_arbiter.sv
// Self-checking bench for bsg_manycore_link_arbiter (4 requesters, max 2 in flight).
module tb_bsg_manycore_link_arbiter;

    localparam int unsigned NUM = 4;
    localparam int unsigned PW  = 16;
    localparam int unsigned MAX = 2;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [3:0]       req_v_i;
    logic [3:0][15:0] req_data_i;
    logic [3:0]       req_ready_o;
    logic             link_v_o;
    logic [15:0]      link_data_o;
    logic             link_ready_i;
    logic             credit_v_i;
    logic [1:0]       credit_id_i;
    logic [3:0][1:0]  out_cnt_o;
    logic             err_o;

    int errors = 0;
    int checks = 0;

    // Reference model state and scoreboard of packets expected on the link.
    logic            m_v;
    logic [3:0][1:0] m_cnt;
    int              m_last;
    logic            m_err;
    logic [15:0]     sb_q[$];

    bsg_manycore_link_arbiter #(
        .num_req_p      (NUM),
        .packet_width_p (PW),
        .max_out_p      (MAX)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_v_i      (req_v_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .link_v_o     (link_v_o),
        .link_data_o  (link_data_o),
        .link_ready_i (link_ready_i),
        .credit_v_i   (credit_v_i),
        .credit_id_i  (credit_id_i),
        .out_cnt_o    (out_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int rr(input logic [3:0] e, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (e[2'(idx)]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_v    = 1'b0;
        m_cnt  = '0;
        m_last = 3;
        m_err  = 1'b0;
        sb_q.delete();
    endtask

    task automatic new_data();
        for (int i = 0; i < 4; i++) req_data_i[2'(i)] = 16'($urandom);
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        req_v_i      = '0;
        credit_v_i   = 1'b0;
        credit_id_i  = '0;
        link_ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        new_data();
    endtask

    // One clock of scoreboard: predict the grant, clock, then compare outputs.
    task automatic tick();
        logic [3:0] elig;
        logic [3:0] exp_rdy;
        logic       sf;
        logic       c_ok;
        logic       inc;
        logic       dec;
        int         w;
        #1;
        sf = !m_v || link_ready_i;
        for (int i = 0; i < 4; i++) elig[2'(i)] = req_v_i[2'(i)] && (m_cnt[2'(i)] < 2'(MAX));
        exp_rdy = '0;
        w = -1;
        if (sf && elig != '0) begin
            w = rr(elig, m_last);
            exp_rdy[2'(w)] = 1'b1;
        end
        checks++;
        if (req_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b at %0t", req_ready_o, exp_rdy, $time);
        end
        if (sf) begin
            if (m_v && link_ready_i) void'(sb_q.pop_front());
            m_v = (w >= 0);
            if (w >= 0) begin
                sb_q.push_back(req_data_i[2'(w)]);
                m_last = w;
            end
        end
        c_ok = credit_v_i && (m_cnt[credit_id_i] != 2'd0);
        if (credit_v_i && !c_ok) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inc = exp_rdy[2'(i)];
            dec = c_ok && (credit_id_i == 2'(i));
            if (inc && !dec) m_cnt[2'(i)] = m_cnt[2'(i)] + 2'd1;
            else if (dec && !inc) m_cnt[2'(i)] = m_cnt[2'(i)] - 2'd1;
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (link_v_o !== m_v) begin
            errors++;
            $display("FAIL link_v: got %b expected %b at %0t", link_v_o, m_v, $time);
        end
        if (m_v) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL link_data: got %h expected nothing queued at %0t", link_data_o, $time);
            end else if (link_data_o !== sb_q[0]) begin
                errors++;
                $display("FAIL link_data: got %h expected %h at %0t", link_data_o, sb_q[0], $time);
            end
        end
        checks++;
        if (out_cnt_o !== m_cnt) begin
            errors++;
            $display("FAIL out_cnt: got %h expected %h at %0t", out_cnt_o, m_cnt, $time);
        end
        checks++;
        if (err_o !== m_err) begin
            errors++;
            $display("FAIL err: got %b expected %b at %0t", err_o, m_err, $time);
        end
        if (w >= 0) req_data_i[2'(w)] = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_i      = 1'b1;
        req_v_i      = 4'hF;
        credit_v_i   = 1'b0;
        credit_id_i  = '0;
        link_ready_i = 1'b1;
        new_data();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (link_v_o !== 1'b0) begin errors++; $display("FAIL reset_link_v: got %b expected 0", link_v_o); end
        checks++;
        if (link_data_o !== 16'h0) begin errors++; $display("FAIL reset_link_data: got %h expected 0", link_data_o); end
        checks++;
        if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready_o); end
        checks++;
        if (out_cnt_o !== 8'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", out_cnt_o); end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        reset_i = 1'b0;
    endtask

    task automatic test_rotation();
        int order[5] = '{0, 1, 2, 3, 0};
        req_v_i      = 4'hF;
        link_ready_i = 1'b1;
        #1;
        checks++;
        if (link_v_o !== 1'b0) begin errors++; $display("FAIL rot_link_v_before: got %b expected 0", link_v_o); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (req_ready_o !== 4'(1 << order[k])) begin
                errors++;
                $display("FAIL rot_order[%0d]: got %b expected %b", k, req_ready_o, 4'(1 << order[k]));
            end
            tick();
            if (k == 0) begin
                checks++;
                if (link_v_o !== 1'b1) begin errors++; $display("FAIL rot_link_v_rise: got %b expected 1", link_v_o); end
            end
            if (k == 3) begin
                checks++;
                if (out_cnt_o !== 8'b01_01_01_01) begin
                    errors++;
                    $display("FAIL rot_cnt: got %b expected 01010101", out_cnt_o);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        do_reset();
        req_v_i = 4'hF;
        tick();
        held = sb_q[0];
        link_ready_i = 1'b0;
        repeat (3) begin
            #1;
            checks++;
            if (req_ready_o !== 4'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", req_ready_o); end
            checks++;
            if (link_data_o !== held) begin errors++; $display("FAIL bp_hold: got %h expected %h", link_data_o, held); end
            tick();
        end
        checks++;
        if (out_cnt_o !== 8'b00_00_00_01) begin errors++; $display("FAIL bp_cnt: got %b expected 00000001", out_cnt_o); end
        link_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_resume: got %b expected 0010", req_ready_o); end
        tick();
    endtask

    task automatic test_credit_limit();
        do_reset();
        req_v_i = 4'b0010;
        tick();
        tick();
        repeat (2) begin
            #1;
            checks++;
            if (req_ready_o !== 4'b0) begin errors++; $display("FAIL lim_ready: got %b expected 0", req_ready_o); end
            tick();
        end
        checks++;
        if (out_cnt_o !== 8'b00_00_10_00) begin errors++; $display("FAIL lim_cnt: got %b expected 00001000", out_cnt_o); end
        credit_v_i  = 1'b1;
        credit_id_i = 2'd1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0) begin errors++; $display("FAIL lim_credit_same: got %b expected 0", req_ready_o); end
        tick();
        credit_v_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL lim_credit_next: got %b expected 0010", req_ready_o); end
        tick();
    endtask

    task automatic test_grant_credit();
        do_reset();
        req_v_i = 4'b0100;
        tick();
        credit_v_i  = 1'b1;
        credit_id_i = 2'd2;
        tick();
        checks++;
        if (out_cnt_o !== 8'b00_01_00_00) begin errors++; $display("FAIL gc_same: got %b expected 00010000", out_cnt_o); end
        req_v_i     = 4'b0;
        credit_id_i = 2'd3;
        tick();
        credit_v_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL gc_underflow_err: got %b expected 1", err_o); end
        checks++;
        if (out_cnt_o !== 8'b00_01_00_00) begin errors++; $display("FAIL gc_underflow_cnt: got %b expected 00010000", out_cnt_o); end
        repeat (3) tick();
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL gc_sticky: got %b expected 1", err_o); end
    endtask

    task automatic test_reset_mid();
        req_v_i      = 4'hF;
        link_ready_i = 1'b1;
        tick();
        tick();
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (link_v_o !== 1'b0) begin errors++; $display("FAIL mid_link_v: got %b expected 0", link_v_o); end
        checks++;
        if (out_cnt_o !== 8'h0) begin errors++; $display("FAIL mid_cnt: got %h expected 0", out_cnt_o); end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err_o); end
        model_reset();
        #1;
        reset_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL mid_first: got %b expected 0001", req_ready_o); end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_credit_limit();
        test_grant_credit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
